rv_regfile_mp: RTL

RV_REGFILE_MP -- requirements
Module: rv_regfile_mp

---
 rtl/rv_regfile_mp.sv | 108 ++++++++++
 1 files changed

// File: rtl/rv_regfile_mp.sv
// Multi-read-port integer register file with two write ports and a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module rv_regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*$clog2(NREG)-1:0] raddr,
    output logic [NRD*XLEN-1:0]         rdata,
    output logic [NRD-1:0]              rbusy,
    input  logic [1:0]                  wen,
    input  logic [2*$clog2(NREG)-1:0]   waddr,
    input  logic [2*XLEN-1:0]           wdata,
    input  logic                        iss_valid,
    input  logic [$clog2(NREG)-1:0]     iss_addr,
    output logic [NREG-1:0]             busy_vec
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [AW-1:0]   waddr0;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata0;
    logic [XLEN-1:0] wdata1;
    logic            wr0_hit;
    logic            wr1_hit;
    logic            iss_hit;

    assign waddr0  = waddr[0  +: AW];
    assign waddr1  = waddr[AW +: AW];
    assign wdata0  = wdata[0    +: XLEN];
    assign wdata1  = wdata[XLEN +: XLEN];
    assign wr0_hit = wen[0] && (waddr0 != '0);
    assign wr1_hit = wen[1] && (waddr1 != '0);
    assign iss_hit = iss_valid && (iss_addr != '0);

    // Update order encodes priority: port 0, then port 1 (wins on collision),
    // then issue (a new issue overrides a completing write), then reset.
    always_comb begin
        // NOTE: next-state starts as a copy of current state so no path can infer a latch.
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_hit) begin
            regs_d[waddr0] = wdata0;
            busy_d[waddr0] = 1'b0;
        end
        if (wr1_hit) begin
            regs_d[waddr1] = wdata1;
            busy_d[waddr1] = 1'b0;
        end
        if (iss_hit) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (rst) begin
            // NOTE: the architectural registers are flops, so clearing every entry on reset is legal and cheap to reason about.
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

    logic [AW-1:0] rd_addr;

    always_comb begin
        rdata   = '0;
        rbusy   = '0;
        rd_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = raddr[k*AW +: AW];
            if (rd_addr != '0) begin
`ifdef REGFILE_BYPASS_EN
                if (wr1_hit && (waddr1 == rd_addr)) begin
                    rdata[k*XLEN +: XLEN] = wdata1;
                    rbusy[k]              = iss_hit && (iss_addr == rd_addr);
                end else if (wr0_hit && (waddr0 == rd_addr)) begin
                    rdata[k*XLEN +: XLEN] = wdata0;
                    rbusy[k]              = iss_hit && (iss_addr == rd_addr);
                end else begin
                    rdata[k*XLEN +: XLEN] = regs_q[rd_addr];
                    rbusy[k]              = busy_q[rd_addr];
                end
`else
                rdata[k*XLEN +: XLEN] = regs_q[rd_addr];
                rbusy[k]              = busy_q[rd_addr];
`endif
            end
        end
    end

endmodule
